// File: rtl/avalon_st_pkt_gen.sv
// Avalon-ST packet generator: emits runs of fixed-length packets whose payload
// is an incrementing byte pattern, with optional inter-packet idle gaps.
module avalon_st_pkt_gen #(
    parameter int unsigned IPG = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cfg_numpkts,
    input  logic [7:0] cfg_start,
    input  logic [7:0] cfg_stop,
    input  logic [7:0] cfg_pktlength,
    input  logic [7:0] cfg_payload,
    input  logic       st_ready,
    output logic       st_valid,
    output logic [7:0] st_data,
    output logic       st_sop,
    output logic       st_eop,
    output logic       busy,
    output logic [7:0] pkt_count,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'((IPG == 0) ? 0 : (IPG - 1));

    state_t     state_r;
    logic       start_prev_r;
    logic       armed_r;
    logic       stop_seen_r;
    logic [7:0] num_r;
    logic [7:0] len_r;
    logic [7:0] pay_r;
    logic [7:0] beat_r;
    logic [3:0] gap_r;
    logic       valid_r;
    logic [7:0] data_r;
    logic       sop_r;
    logic       eop_r;
    logic       busy_r;
    logic [7:0] count_r;
    logic       done_r;

    logic       start_edge_s;
    logic       xfer_s;
    logic [7:0] next_count_s;
    logic       end_after_eop_s;
    logic       unused_cfg_bits_s;

    // armed_r keeps a start level already present at reset release from looking like an edge
    assign start_edge_s      = armed_r && cfg_start[0] && !start_prev_r;
    assign xfer_s            = valid_r && st_ready;
    assign next_count_s      = count_r + 8'd1;
    assign end_after_eop_s   = ((num_r != 8'd0) && (next_count_s == num_r)) || cfg_stop[0];
    assign unused_cfg_bits_s = ^{cfg_start[7:1], cfg_stop[7:1]};

    assign st_valid  = valid_r;
    assign st_data   = data_r;
    assign st_sop    = sop_r;
    assign st_eop    = eop_r;
    assign busy      = busy_r;
    assign pkt_count = count_r;
    assign done      = done_r;

    // Run-control FSM and all registered Avalon-ST / status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            start_prev_r <= 1'b0;
            armed_r      <= 1'b0;
            stop_seen_r  <= 1'b0;
            num_r        <= 8'd0;
            len_r        <= 8'd0;
            pay_r        <= 8'd0;
            beat_r       <= 8'd0;
            gap_r        <= 4'd0;
            valid_r      <= 1'b0;
            data_r       <= 8'd0;
            sop_r        <= 1'b0;
            eop_r        <= 1'b0;
            busy_r       <= 1'b0;
            count_r      <= 8'd0;
            done_r       <= 1'b0;
        end else begin
            start_prev_r <= cfg_start[0];
            armed_r      <= 1'b1;
            done_r       <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_edge_s && (cfg_pktlength != 8'd0) && !cfg_stop[0]) begin
                        num_r   <= cfg_numpkts;
                        len_r   <= cfg_pktlength;
                        pay_r   <= cfg_payload;
                        count_r <= 8'd0;
                        busy_r  <= 1'b1;
                        beat_r  <= 8'd0;
                        valid_r <= 1'b1;
                        data_r  <= cfg_payload;
                        sop_r   <= 1'b1;
                        eop_r   <= (cfg_pktlength == 8'd1);
                        state_r <= S_SEND;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (xfer_s) begin
                        if (eop_r) begin
                            count_r <= next_count_s;
                            if (end_after_eop_s) begin
                                valid_r <= 1'b0;
                                sop_r   <= 1'b0;
                                eop_r   <= 1'b0;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= S_IDLE;
                            end else if (IPG == 0) begin
                                beat_r  <= 8'd0;
                                data_r  <= pay_r;
                                sop_r   <= 1'b1;
                                eop_r   <= (len_r == 8'd1);
                                state_r <= S_SEND;
                            end else begin
                                valid_r     <= 1'b0;
                                sop_r       <= 1'b0;
                                eop_r       <= 1'b0;
                                gap_r       <= 4'd0;
                                stop_seen_r <= 1'b0;
                                state_r     <= S_GAP;
                            end
                        end else begin
                            beat_r <= beat_r + 8'd1;
                            data_r <= data_r + 8'd1;
                            sop_r  <= 1'b0;
                            eop_r  <= ((beat_r + 8'd2) == len_r);
                        end
                    end else begin
                        state_r <= S_SEND;
                    end
                end
                S_GAP: begin
                    // a stop seen anywhere in the gap is honoured when the gap expires
                    if (gap_r == GAP_LAST) begin
                        if (stop_seen_r || cfg_stop[0]) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            beat_r  <= 8'd0;
                            valid_r <= 1'b1;
                            data_r  <= pay_r;
                            sop_r   <= 1'b1;
                            eop_r   <= (len_r == 8'd1);
                            state_r <= S_SEND;
                        end
                    end else begin
                        gap_r       <= gap_r + 4'd1;
                        stop_seen_r <= stop_seen_r | cfg_stop[0];
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    sop_r   <= 1'b0;
                    eop_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// Randomized bench for avalon_st_pkt_gen: two instances (IPG=0 and IPG=3) share
// stimulus; observed transfers are compared against a packet-level model.
module tb_avalon_st_pkt_gen;

    localparam int IPG_A = 0;
    localparam int IPG_B = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] cfg_numpkts, cfg_start, cfg_stop, cfg_pktlength, cfg_payload;
    logic       st_ready;
    logic       v [2];
    logic       sop [2];
    logic       eop [2];
    logic       busy [2];
    logic       done [2];
    logic [7:0] data [2];
    logic [7:0] pc [2];

    int errors = 0;
    int checks = 0;

    avalon_st_pkt_gen #(.IPG(IPG_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .cfg_numpkts(cfg_numpkts), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .cfg_pktlength(cfg_pktlength), .cfg_payload(cfg_payload),
        .st_ready(st_ready), .st_valid(v[0]), .st_data(data[0]), .st_sop(sop[0]),
        .st_eop(eop[0]), .busy(busy[0]), .pkt_count(pc[0]), .done(done[0])
    );

    avalon_st_pkt_gen #(.IPG(IPG_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .cfg_numpkts(cfg_numpkts), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .cfg_pktlength(cfg_pktlength), .cfg_payload(cfg_payload),
        .st_ready(st_ready), .st_valid(v[1]), .st_data(data[1]), .st_sop(sop[1]),
        .st_eop(eop[1]), .busy(busy[1]), .pkt_count(pc[1]), .done(done[1])
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got=%0h expected=%0h", tag, idx, got, exp);
        end
    endtask

    // Sink ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random
    int ready_mode = 0;
    int rdy_phase  = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: st_ready = 1'b1;
            1: st_ready = ((rdy_phase % 3) == 0);
            default: st_ready = ($urandom_range(0, 3) != 0);
        endcase
        rdy_phase++;
    end

    // Monitor state
    int         ipg_of [2] = '{IPG_A, IPG_B};
    logic [9:0] obs0[$];
    logic [9:0] obs1[$];
    int         eops [2];
    int         done_cnt [2];
    int         done_cyc [2];
    int         eop_cyc [2];
    int         gap_run [2];
    bit         in_pkt [2];
    bit         seen_eop [2];
    bit         pv [2];
    bit         pr [2];
    logic [9:0] pbeat [2];
    bit         mon_en = 1'b0;
    int         cyc = 0;

    // Transfer monitor: records beats and checks stall hold, mid-packet valid and gap length
    always @(negedge clk) begin
        cyc++;
        if (reset_n && mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (pv[i] && !pr[i])
                    check_eq("stall_hold", i, {21'd0, v[i], data[i], sop[i], eop[i]}, {21'd0, 1'b1, pbeat[i]});
                if (in_pkt[i])
                    check_eq("valid_in_pkt", i, 32'(v[i]), 32'd1);
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                if (busy[i] && !v[i] && seen_eop[i])
                    gap_run[i]++;
                if (v[i] && st_ready) begin
                    if (sop[i] && seen_eop[i])
                        check_eq("ipg", i, gap_run[i], ipg_of[i]);
                    if (i == 0) obs0.push_back({data[i], sop[i], eop[i]});
                    else        obs1.push_back({data[i], sop[i], eop[i]});
                    in_pkt[i] = !eop[i];
                    if (eop[i]) begin
                        seen_eop[i] = 1'b1;
                        gap_run[i]  = 0;
                        eops[i]++;
                        eop_cyc[i]  = cyc;
                    end
                end
                pv[i]    = v[i];
                pr[i]    = st_ready;
                pbeat[i] = {data[i], sop[i], eop[i]};
            end
        end
    end

    task automatic clear_mon();
        obs0.delete();
        obs1.delete();
        for (int i = 0; i < 2; i++) begin
            eops[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0; eop_cyc[i] = 0; gap_run[i] = 0;
            in_pkt[i] = 1'b0; seen_eop[i] = 1'b0; pv[i] = 1'b0; pr[i] = 1'b0;
        end
    endtask

    // One run: num packets (0 = continuous), stop raised once stop_after packets are done
    task automatic run_case(input int num, input int len, input logic [7:0] pay, input int rmode, input int stop_after);
        int   exp_cnt [2];
        bit   finished;
        logic [9:0] w, e;
        clear_mon();
        mon_en     = 1'b1;
        ready_mode = rmode;
        exp_cnt[0] = num;
        exp_cnt[1] = num;
        @(posedge clk); #1;
        cfg_numpkts = 8'(num); cfg_pktlength = 8'(len); cfg_payload = pay;
        cfg_stop = 8'd0; cfg_start = 8'h01;
        @(posedge clk); #1;
        cfg_start = 8'h00;
        cfg_numpkts = 8'($urandom); cfg_pktlength = 8'($urandom); cfg_payload = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            check_eq("busy_at_start", i, 32'(busy[i]), 32'd1);
            check_eq("sop_at_start", i, 32'(v[i] && sop[i]), 32'd1);
        end
        if (num == 0 || num * len >= 8) begin
            repeat (3) @(posedge clk);
            #1 cfg_start = 8'hFF;
            @(posedge clk); #1 cfg_start = 8'h00;
        end
        if (stop_after >= 0) begin
            finished = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                @(posedge clk); #1;
                if (eops[0] >= stop_after && eops[1] >= stop_after && v[1]) begin
                    finished = 1'b1;
                    break;
                end
            end
            check_eq("stop_wait_timeout", 0, 32'(finished), 32'd1);
            for (int i = 0; i < 2; i++) exp_cnt[i] = eops[i] + (v[i] ? 1 : 0);
            cfg_stop = 8'h01;
        end
        finished = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(posedge clk); #1;
            if (!busy[0] && !busy[1] && done_cnt[0] >= 1 && done_cnt[1] >= 1) begin
                finished = 1'b1;
                break;
            end
        end
        check_eq("run_timeout", 0, 32'(finished), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        cfg_stop = 8'd0;
        for (int i = 0; i < 2; i++) begin
            check_eq("done_pulses", i, done_cnt[i], 1);
            check_eq("busy_end", i, 32'(busy[i]), 32'd0);
            check_eq("valid_end", i, 32'(v[i]), 32'd0);
            check_eq("pkt_count", i, 32'(pc[i]), 32'(exp_cnt[i] % 256));
            check_eq("beat_total", i, (i == 0) ? obs0.size() : obs1.size(), exp_cnt[i] * len);
            if (stop_after < 0)
                check_eq("done_latency", i, done_cyc[i] - eop_cyc[i], 1);
            for (int p = 0; p < exp_cnt[i]; p++) begin
                for (int k = 0; k < len; k++) begin
                    int j = p * len + k;
                    e = {8'(pay + 8'(k)), (k == 0), (k == len - 1)};
                    if (j < ((i == 0) ? obs0.size() : obs1.size())) begin
                        w = (i == 0) ? obs0[j] : obs1[j];
                        check_eq("beat", i, 32'(w), 32'(e));
                    end
                end
            end
        end
        mon_en = 1'b0;
    endtask

    // Start edge that must be ignored: nothing may happen for a few cycles
    task automatic ignored_start(input logic [7:0] len, input logic [7:0] stop);
        @(posedge clk); #1;
        cfg_numpkts = 8'd1; cfg_pktlength = len; cfg_payload = 8'h55; cfg_stop = stop; cfg_start = 8'h01;
        @(posedge clk); #1 cfg_start = 8'h00;
        repeat (4) begin
            for (int i = 0; i < 2; i++)
                check_eq("ignored_start", i, {29'd0, v[i], busy[i], done[i]}, 32'd0);
            @(posedge clk); #1;
        end
        cfg_stop = 8'd0;
    endtask

    initial begin
        bit hit;
        reset_n = 1'b0;
        cfg_numpkts = 8'd0; cfg_start = 8'd0; cfg_stop = 8'd0; cfg_pktlength = 8'd0; cfg_payload = 8'd0;
        #1;
        for (int i = 0; i < 2; i++)
            check_eq("reset_state", i, {13'd0, v[i], data[i], sop[i], eop[i], busy[i], pc[i], done[i]}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        run_case(2, 3, 8'h10, 0, -1);
        run_case(1, 1, 8'hFF, 0, -1);
        run_case(2, 4, 8'($urandom), 1, -1);
        run_case(0, 2, 8'hF0, 0, 4);
        ignored_start(8'd0, 8'd0);
        ignored_start(8'd3, 8'd1);

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 2) == 0)
                run_case(0, $urandom_range(1, 6), 8'($urandom), $urandom_range(0, 2), $urandom_range(1, 3));
            else
                run_case($urandom_range(1, 4), $urandom_range(1, 6), 8'($urandom), $urandom_range(0, 2), -1);
        end

        // Reset in the middle of a 5-beat packet, with start held high across release
        ready_mode = 0;
        @(posedge clk); #1;
        cfg_numpkts = 8'd1; cfg_pktlength = 8'd5; cfg_payload = 8'h30; cfg_start = 8'h01;
        hit = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (v[0] && data[0] == 8'h32) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("reach_beat2", 0, 32'(hit), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check_eq("async_reset", i, {13'd0, v[i], data[i], sop[i], eop[i], busy[i], pc[i], done[i]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++)
                check_eq("quiet_after_reset", i, {29'd0, v[i], busy[i], done[i]}, 32'd0);
        end
        cfg_start = 8'h00;
        repeat (2) @(posedge clk);
        run_case(2, 5, 8'hFE, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avalon_st_pkt_gen.md
AVALON_ST_PKT_GEN -- requirements
Module: avalon_st_pkt_gen

Interface
REQ-001 Parameter IPG, default 0, meaning: idle cycles inserted between the eop beat and the next sop beat; legal range 0..15.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_numpkts  input  8  packets per run; 0 = continuous until stop.
REQ-005 cfg_start  input  8  bit0 rising edge requests a run; bits 7:1 ignored.
REQ-006 cfg_stop  input  8  bit0 level high requests stop; bits 7:1 ignored.
REQ-007 cfg_pktlength  input  8  beats per packet; 0 is illegal (start ignored).
REQ-008 cfg_payload  input  8  seed byte for the payload pattern.
REQ-009 st_ready  input  1  Avalon-ST sink ready.
REQ-010 st_valid  output  1  Avalon-ST beat valid.
REQ-011 st_data  output  8  Avalon-ST data byte.
REQ-012 st_sop  output  1  first beat of packet.
REQ-013 st_eop  output  1  last beat of packet.
REQ-014 busy  output  1  high from run start until run end.
REQ-015 pkt_count  output  8  packets completed in current/last run.
REQ-016 done  output  1  one-cycle pulse at run end.

Function
REQ-017 States: IDLE, SEND, GAP; all outputs registered.
REQ-018 Start edge = cfg_start[0] high this cycle and low the previous sampled cycle (edge register clears on reset).
REQ-019 IDLE: start edge with cfg_pktlength != 0 and cfg_stop[0] low -> latch numpkts/pktlength/payload, clear pkt_count, busy=1, go SEND; st_valid=1 with st_sop=1 on the next cycle.
REQ-020 IDLE: start edge with cfg_pktlength == 0 or cfg_stop[0] high -> ignored, stay IDLE, no done.
REQ-021 Config inputs changed during a run have no effect until the next start.
REQ-022 Beat k (k = 0..len-1) of every packet: st_data = (payload + k) mod 256; st_sop = (k == 0); st_eop = (k == len-1); len 1 gives sop and eop on the same beat.
REQ-023 Transfer occurs only when st_valid && st_ready; while st_valid=1 and st_ready=0, st_data/st_sop/st_eop hold stable.
REQ-024 st_valid is asserted only in SEND and never deasserts mid-packet.
REQ-025 On eop transfer: pkt_count increments (8-bit wrap 255->0); then the run ends if numpkts != 0 and new count == numpkts, or if cfg_stop[0] is high that cycle.
REQ-026 Run end: st_valid=0, busy=0, done=1 for exactly one cycle, go IDLE; pkt_count holds.
REQ-027 Not ending: IPG == 0 -> next sop beat valid the following cycle (back-to-back); IPG > 0 -> GAP for exactly IPG cycles with st_valid=0, then SEND.
REQ-028 cfg_stop[0] high during GAP ends the run at the end of the gap, with no new sop.
REQ-029 Stop never truncates a packet: a stop deasserted before the eop transfer has no effect.
REQ-030 Start edges during SEND or GAP are ignored.
REQ-031 Continuous mode (numpkts == 0) runs until stop; pkt_count wraps freely.

Reset
REQ-032 reset_n low forces, asynchronously: state IDLE, st_valid=0, st_sop=0, st_eop=0, st_data=0, busy=0, done=0, pkt_count=0, beat and gap counters 0, start-edge register 0.
REQ-033 Reset mid-packet abandons the packet; after release no beat is driven until a new start edge.
REQ-034 cfg_start[0] already high at reset release does not count as an edge.

Verification
REQ-035 numpkts=2, pktlength=3, payload=0x10, IPG=0, st_ready=1, start edge -> beats 10(sop),11,12(eop),10(sop),11,12(eop) back-to-back; done pulse; pkt_count=2; busy=0.
REQ-036 pktlength=1, numpkts=1, payload=0xFF -> single beat data=FF with sop=eop=1; done one cycle after the transfer.
REQ-037 pktlength=4, st_ready toggling 1,0,0,1,... -> data sequence unchanged, stable while stalled, no beat lost or duplicated.
REQ-038 numpkts=0, pktlength=2, IPG=3, stop raised mid-packet 5 -> packet 5 completes, 3 gap cycles between packets observed, run ends, pkt_count=5.
REQ-039 pktlength=0, start edge -> no st_valid, busy=0, no done.
REQ-040 reset_n asserted during beat 2 of a 5-beat packet -> outputs zero immediately; no output activity after release until a new start edge.
